// File: rtl/microwave_timer_pkg.sv
// Shared definitions for the microwave countdown timer: BCD widths, digit limits,
// the default tick divider and the derived operating states.
package microwave_timer_pkg;

  localparam int              BCD_W            = 4;
  localparam logic [BCD_W-1:0] SEC_TENS_MAX    = 4'd5;
  localparam logic [BCD_W-1:0] DIGIT_MAX       = 4'd9;
  localparam int              TICK_DIV_DEFAULT = 50_000_000;

  typedef enum logic [1:0] {
    ST_SETUP = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2
  } tmr_state_e;

  function automatic logic is_bcd(input logic [BCD_W-1:0] d);
    return (d <= DIGIT_MAX);
  endfunction

  // Operating state is a pure function of mag_on and the zero decode.
  function automatic tmr_state_e state_of(input logic mag_on, input logic zero);
    tmr_state_e st;
    if (zero) begin
      st = ST_DONE;
    end else if (mag_on) begin
      st = ST_RUN;
    end else begin
      st = ST_SETUP;
    end
    return st;
  endfunction

endpackage

// File: rtl/microwave_timer_bcd_digit_dec.sv
// One BCD display digit: shift-load, decrement on borrow-in, reload and borrow-out
// when asked to decrement from zero.
module bcd_digit_dec
  import microwave_timer_pkg::*;
#(
  parameter logic [BCD_W-1:0] RELOAD = 4'd9
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_dec,
  input  logic             i_load,
  input  logic [BCD_W-1:0] i_load_val,
  output logic [BCD_W-1:0] o_digit,
  output logic             o_borrow
);

  logic [BCD_W-1:0] r_digit;

  // Digit register: clear beats decrement beats load.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_digit <= 4'd0;
    end else if (i_clr) begin
      r_digit <= 4'd0;
    end else if (i_dec) begin
      r_digit <= (r_digit == 4'd0) ? RELOAD : (r_digit - 4'd1);
    end else if (i_load) begin
      r_digit <= i_load_val;
    end else begin
      r_digit <= r_digit;
    end
  end

  assign o_digit  = r_digit;
  assign o_borrow = i_dec && (r_digit == 4'd0);

endmodule

// File: rtl/microwave_timer.sv
// MM:SS countdown timer: keypad shift-load while idle, one-second prescaled
// decrement while the magnetron runs, done decode and one-shot done pulse.
module microwave_timer
  import microwave_timer_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clearn,
  input  logic             i_mag_on,
  input  logic             i_key_valid,
  input  logic [BCD_W-1:0] i_key_digit,
  output logic [BCD_W-1:0] o_min_tens,
  output logic [BCD_W-1:0] o_min_ones,
  output logic [BCD_W-1:0] o_sec_tens,
  output logic [BCD_W-1:0] o_sec_ones,
  output logic             o_timer_done,
  output logic             o_done_pulse
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0]    r_presc;
  logic             r_done_pulse;
  logic [BCD_W-1:0] w_digit    [4];
  logic [BCD_W-1:0] w_load_val [4];
  logic [4:0]       w_req;
  logic             w_zero;
  logic             w_tick;
  logic             w_last;
  logic             w_key_ok;
  logic             w_clr;
  logic             w_unused_borrow;
  tmr_state_e       w_state;

  assign w_clr    = !i_clearn;
  assign w_zero   = (w_digit[0] == 4'd0) && (w_digit[1] == 4'd0) &&
                    (w_digit[2] == 4'd0) && (w_digit[3] == 4'd0);
  assign w_state  = state_of(i_mag_on, w_zero);
  assign w_tick   = (w_state == ST_RUN) && (r_presc == PRESC_MAX);
  // Only a count of exactly 00:01 can step to 00:00.
  assign w_last   = w_tick && (w_digit[0] == 4'd1) && (w_digit[1] == 4'd0) &&
                    (w_digit[2] == 4'd0) && (w_digit[3] == 4'd0);
  assign w_key_ok = !i_mag_on && i_key_valid && is_bcd(i_key_digit);

  assign w_load_val[0] = i_key_digit;
  assign w_load_val[1] = w_digit[0];
  assign w_load_val[2] = w_digit[1];
  assign w_load_val[3] = w_digit[2];

  assign w_req[0]        = w_tick;
  assign w_unused_borrow = w_req[4];

  // Index 0 is sec_ones; borrows ripple upward.
  bcd_digit_dec #(.RELOAD(DIGIT_MAX)) u_sec_ones (
    .i_clk(i_clk), .i_rst(i_rst), .i_clr(w_clr), .i_dec(w_req[0]),
    .i_load(w_key_ok), .i_load_val(w_load_val[0]),
    .o_digit(w_digit[0]), .o_borrow(w_req[1])
  );

  bcd_digit_dec #(.RELOAD(SEC_TENS_MAX)) u_sec_tens (
    .i_clk(i_clk), .i_rst(i_rst), .i_clr(w_clr), .i_dec(w_req[1]),
    .i_load(w_key_ok), .i_load_val(w_load_val[1]),
    .o_digit(w_digit[1]), .o_borrow(w_req[2])
  );

  bcd_digit_dec #(.RELOAD(DIGIT_MAX)) u_min_ones (
    .i_clk(i_clk), .i_rst(i_rst), .i_clr(w_clr), .i_dec(w_req[2]),
    .i_load(w_key_ok), .i_load_val(w_load_val[2]),
    .o_digit(w_digit[2]), .o_borrow(w_req[3])
  );

  bcd_digit_dec #(.RELOAD(DIGIT_MAX)) u_min_tens (
    .i_clk(i_clk), .i_rst(i_rst), .i_clr(w_clr), .i_dec(w_req[3]),
    .i_load(w_key_ok), .i_load_val(w_load_val[3]),
    .o_digit(w_digit[3]), .o_borrow(w_req[4])
  );

  // Prescaler only runs in RUN, so a pause keeps the partial second.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_presc <= '0;
    end else if (w_clr) begin
      r_presc <= '0;
    end else if (w_state == ST_RUN) begin
      r_presc <= (r_presc == PRESC_MAX) ? '0 : (r_presc + PW'(1));
    end else begin
      r_presc <= r_presc;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_done_pulse <= 1'b0;
    end else if (w_clr) begin
      r_done_pulse <= 1'b0;
    end else begin
      r_done_pulse <= w_last;
    end
  end

  assign o_sec_ones   = w_digit[0];
  assign o_sec_tens   = w_digit[1];
  assign o_min_ones   = w_digit[2];
  assign o_min_tens   = w_digit[3];
  assign o_timer_done = w_zero;
  assign o_done_pulse = r_done_pulse;

endmodule
